// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the hardwired control unit of the single-bus datapath:
//   - sequencer state encoding (fetch T0-T2, execute T3-T6, unary U4-U5, halt, step wait)
//   - opcode class encoding produced by the instruction decoder
//   - opcode values and IR field bit positions
//   - the per-cycle control word registered by the sequencer
//   - helper functions classifying an opcode
package cpu_ctrl_pkg;

    localparam int OPC_FIELD_W   = 5;
    localparam int RADDR_FIELD_W = 4;

    // IR field positions, given as the MSB of each field (fields run downward)
    localparam int OPC_MSB = 31;
    localparam int RA_MSB  = 26;
    localparam int RB_MSB  = 22;
    localparam int RC_MSB  = 18;

    localparam logic [OPC_FIELD_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_FIELD_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_FIELD_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPC_FIELD_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPC_FIELD_W-1:0] OPC_SHR  = 5'b00111;
    localparam logic [OPC_FIELD_W-1:0] OPC_SHL  = 5'b01001;
    localparam logic [OPC_FIELD_W-1:0] OPC_ROR  = 5'b01010;
    localparam logic [OPC_FIELD_W-1:0] OPC_ROL  = 5'b01011;
    localparam logic [OPC_FIELD_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPC_FIELD_W-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OPC_FIELD_W-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPC_FIELD_W-1:0] OPC_NOT  = 5'b10010;
    localparam logic [OPC_FIELD_W-1:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        U4,
        U5,
        HALTED,
        STEP_WAIT
    } state_t;

    typedef enum logic [2:0] {
        CLS_3OP,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_HALT,
        CLS_ILLEGAL
    } opc_class_t;

    // One bit per single-wire control output; addresses and opcode travel separately
    typedef struct packed {
        logic pcSelect;
        logic zLoSelect;
        logic zHiSelect;
        logic mdrSelect;
        logic pcEnable;
        logic pcIncrementEnable;
        logic irEnable;
        logic yEnable;
        logic zEnable;
        logic marEnable;
        logic mdrEnable;
        logic read;
        logic hiEnable;
        logic loEnable;
        logic rfOutEn;
        logic rfWriteEn;
        logic halted;
        logic instrDone;
    } ctrl_t;

    function automatic logic is_3op(input logic [OPC_FIELD_W-1:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
            OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_muldiv(input logic [OPC_FIELD_W-1:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction

    function automatic logic is_unary(input logic [OPC_FIELD_W-1:0] opc);
        return (opc == OPC_NEG) || (opc == OPC_NOT);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder
// Purely combinational split of the instruction register into its opcode class
// and operand fields. The sequencer latches these outputs on entry to decode.
// Ports:
//   irData_i    in   32        current IR contents
//   opc_o       out  OPC_W     opcode field
//   ra_o        out  RADDR_W   ra field (destination)
//   rb_o        out  RADDR_W   rb field
//   rc_o        out  RADDR_W   rc field
//   opcClass_o  out  class     3-operand / mul-div / unary / halt / illegal
module instr_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W   = OPC_FIELD_W,
    parameter int RADDR_W = RADDR_FIELD_W
) (
    input  logic [31:0]        irData_i,
    output logic [OPC_W-1:0]   opc_o,
    output logic [RADDR_W-1:0] ra_o,
    output logic [RADDR_W-1:0] rb_o,
    output logic [RADDR_W-1:0] rc_o,
    output opc_class_t         opcClass_o
);

    logic [OPC_FIELD_W-1:0] opcField;
    logic                   unusedLowBits;

    assign opc_o         = irData_i[OPC_MSB -: OPC_W];
    assign ra_o          = irData_i[RA_MSB -: RADDR_W];
    assign rb_o          = irData_i[RB_MSB -: RADDR_W];
    assign rc_o          = irData_i[RC_MSB -: RADDR_W];
    assign opcField      = irData_i[OPC_MSB -: OPC_FIELD_W];
    assign unusedLowBits = ^irData_i[RC_MSB-RADDR_W:0];

    // Classify the opcode; anything not recognised is treated as illegal,
    // which the sequencer handles identically to HALT.
    always_comb begin
        if (is_3op(opcField)) begin
            opcClass_o = CLS_3OP;
        end else if (is_muldiv(opcField)) begin
            opcClass_o = CLS_MULDIV;
        end else if (is_unary(opcField)) begin
            opcClass_o = CLS_UNARY;
        end else if (opcField == OPC_HALT) begin
            opcClass_o = CLS_HALT;
        end else begin
            opcClass_o = CLS_ILLEGAL;
        end
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer
// Hardwired control unit for the single-bus datapath. Runs fetch (T0-T2),
// decode (T3) and execute (T4-T6, or U4-U5 for unary ops) of register-to-register
// ALU instructions and drives every enable/select/opcode line of the datapath.
// All outputs are registered: each is the decode of the state being entered,
// so they are stable for the whole cycle spent in that state.
// Optional build macro: SINGLE_STEP_EN adds input 'step'; after each completed
// instruction the sequencer parks in STEP_WAIT until step=1 (with run=1).
// Ports:
//   clk, reset (async, active-high), run, mem_ready, ir_in[31:0], [step]
//   bus selects:   PC_select, Z_LO_select, Z_HI_select, MDR_select, rf_out_en
//   loads/memory:  PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
//                  MAR_enable, MDR_enable, read, HI_enable, LO_enable, rf_write_en
//   fields:        rf_out_addr, rf_write_addr, alu_instruction
//   status:        halted (sticky), instr_done (pulse in final execute state)
module alu_instr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W              = OPC_FIELD_W,
    parameter int RADDR_W            = RADDR_FIELD_W,
    parameter int RESUME_IDLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
`ifdef SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic               run,
    input  logic               mem_ready,
    input  logic [31:0]        ir_in,
    output logic               PC_select,
    output logic               Z_LO_select,
    output logic               Z_HI_select,
    output logic               MDR_select,
    output logic               PC_enable,
    output logic               PC_increment_enable,
    output logic               IR_enable,
    output logic               Y_enable,
    output logic               Z_enable,
    output logic               MAR_enable,
    output logic               MDR_enable,
    output logic               read,
    output logic               HI_enable,
    output logic               LO_enable,
    output logic               rf_out_en,
    output logic [RADDR_W-1:0] rf_out_addr,
    output logic               rf_write_en,
    output logic [RADDR_W-1:0] rf_write_addr,
    output logic [OPC_W-1:0]   alu_instruction,
    output logic               halted,
    output logic               instr_done
);

    localparam int IDLE_CNT_W = (RESUME_IDLE_CYCLES > 1) ? $clog2(RESUME_IDLE_CYCLES) : 1;
    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST =
        (RESUME_IDLE_CYCLES > 1) ? IDLE_CNT_W'(RESUME_IDLE_CYCLES - 1) : '0;

    state_t                 state_q, stateD;
    logic [IDLE_CNT_W-1:0]  idleCnt_q, idleCntD;
    ctrl_t                  ctrl_q, ctrlD;
    logic [RADDR_W-1:0]     rfOutAddr_q, rfOutAddrD;
    logic [RADDR_W-1:0]     rfWriteAddr_q, rfWriteAddrD;
    logic [OPC_W-1:0]       aluInstr_q, aluInstrD;

    logic [OPC_W-1:0]       opc_q;
    logic [RADDR_W-1:0]     ra_q, rb_q, rc_q;
    opc_class_t             cls_q;

    logic [OPC_W-1:0]       decOpc;
    logic [RADDR_W-1:0]     decRa, decRb, decRc;
    opc_class_t             decCls;
    state_t                 afterDone;

    instr_decoder #(
        .OPC_W   (OPC_W),
        .RADDR_W (RADDR_W)
    ) u_decoder (
        .irData_i   (ir_in),
        .opc_o      (decOpc),
        .ra_o       (decRa),
        .rb_o       (decRb),
        .rc_o       (decRc),
        .opcClass_o (decCls)
    );

    // Where to go once an instruction has signalled instr_done. With single-step
    // builds every instruction parks in STEP_WAIT; otherwise run decides.
    always_comb begin
`ifdef SINGLE_STEP_EN
        afterDone = STEP_WAIT;
`else
        afterDone = run ? T0 : IDLE;
`endif
    end

    // Next-state logic. IDLE waits RESUME_IDLE_CYCLES cycles of run=1 before
    // fetching; T1 holds until memory data is valid; T3 branches on opcode class.
    always_comb begin
        stateD   = state_q;
        idleCntD = '0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    if (idleCnt_q == IDLE_LAST) begin
                        stateD = T0;
                    end else begin
                        idleCntD = idleCnt_q + IDLE_CNT_W'(1);
                    end
                end
            end
            T0: stateD = T1;
            T1: stateD = mem_ready ? T2 : T1;
            T2: stateD = T3;
            T3: begin
                case (cls_q)
                    CLS_3OP, CLS_MULDIV: stateD = T4;
                    CLS_UNARY:           stateD = U4;
                    default:             stateD = HALTED;
                endcase
            end
            T4: stateD = T5;
            T5: stateD = (cls_q == CLS_MULDIV) ? T6 : afterDone;
            T6: stateD = afterDone;
            U4: stateD = U5;
            U5: stateD = afterDone;
            HALTED: stateD = HALTED;
            STEP_WAIT: begin
`ifdef SINGLE_STEP_EN
                if (!run) begin
                    stateD = IDLE;
                end else if (step) begin
                    stateD = T0;
                end
`else
                stateD = IDLE;
`endif
            end
            default: stateD = IDLE;
        endcase
    end

    // Output decode of the state being entered. Entering T3 is the edge on
    // which the IR fields get latched, so T3 reads the decoder directly while
    // later execute states read the latched copies. PC_enable in T1 only fires
    // on the cycle coming from T0, so a stalled fetch increments the PC once.
    always_comb begin
        ctrlD        = '0;
        rfOutAddrD   = '0;
        rfWriteAddrD = '0;
        aluInstrD    = '0;
        case (stateD)
            T0: begin
                ctrlD.pcSelect          = 1'b1;
                ctrlD.marEnable         = 1'b1;
                ctrlD.pcIncrementEnable = 1'b1;
                ctrlD.zEnable           = 1'b1;
            end
            T1: begin
                ctrlD.zLoSelect = 1'b1;
                ctrlD.pcEnable  = (state_q == T0);
                ctrlD.read      = 1'b1;
                ctrlD.mdrEnable = 1'b1;
            end
            T2: begin
                ctrlD.mdrSelect = 1'b1;
                ctrlD.irEnable  = 1'b1;
            end
            T3: begin
                if (decCls == CLS_3OP) begin
                    ctrlD.rfOutEn = 1'b1;
                    ctrlD.yEnable = 1'b1;
                    rfOutAddrD    = decRb;
                end else if (decCls == CLS_MULDIV) begin
                    ctrlD.rfOutEn = 1'b1;
                    ctrlD.yEnable = 1'b1;
                    rfOutAddrD    = decRa;
                end
            end
            T4: begin
                ctrlD.rfOutEn = 1'b1;
                ctrlD.zEnable = 1'b1;
                rfOutAddrD    = (cls_q == CLS_MULDIV) ? rb_q : rc_q;
                aluInstrD     = opc_q;
            end
            T5: begin
                ctrlD.zLoSelect = 1'b1;
                if (cls_q == CLS_MULDIV) begin
                    ctrlD.loEnable = 1'b1;
                end else begin
                    ctrlD.rfWriteEn = 1'b1;
                    ctrlD.instrDone = 1'b1;
                    rfWriteAddrD    = ra_q;
                end
            end
            T6: begin
                ctrlD.zHiSelect = 1'b1;
                ctrlD.hiEnable  = 1'b1;
                ctrlD.instrDone = 1'b1;
            end
            U4: begin
                ctrlD.rfOutEn = 1'b1;
                ctrlD.zEnable = 1'b1;
                rfOutAddrD    = rb_q;
                aluInstrD     = opc_q;
            end
            U5: begin
                ctrlD.zLoSelect = 1'b1;
                ctrlD.rfWriteEn = 1'b1;
                ctrlD.instrDone = 1'b1;
                rfWriteAddrD    = ra_q;
            end
            HALTED: begin
                ctrlD.halted = 1'b1;
            end
            default: begin
                ctrlD = '0;
            end
        endcase
    end

    // State, latched instruction fields and registered outputs. Reset is
    // asynchronous so a stalled memory read is dropped immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idleCnt_q     <= '0;
            ctrl_q        <= '0;
            rfOutAddr_q   <= '0;
            rfWriteAddr_q <= '0;
            aluInstr_q    <= '0;
            opc_q         <= '0;
            ra_q          <= '0;
            rb_q          <= '0;
            rc_q          <= '0;
            cls_q         <= CLS_3OP;
        end else begin
            state_q       <= stateD;
            idleCnt_q     <= idleCntD;
            ctrl_q        <= ctrlD;
            rfOutAddr_q   <= rfOutAddrD;
            rfWriteAddr_q <= rfWriteAddrD;
            aluInstr_q    <= aluInstrD;
            if (stateD == T3) begin
                opc_q <= decOpc;
                ra_q  <= decRa;
                rb_q  <= decRb;
                rc_q  <= decRc;
                cls_q <= decCls;
            end
        end
    end

    assign PC_select           = ctrl_q.pcSelect;
    assign Z_LO_select         = ctrl_q.zLoSelect;
    assign Z_HI_select         = ctrl_q.zHiSelect;
    assign MDR_select          = ctrl_q.mdrSelect;
    assign PC_enable           = ctrl_q.pcEnable;
    assign PC_increment_enable = ctrl_q.pcIncrementEnable;
    assign IR_enable           = ctrl_q.irEnable;
    assign Y_enable            = ctrl_q.yEnable;
    assign Z_enable            = ctrl_q.zEnable;
    assign MAR_enable          = ctrl_q.marEnable;
    assign MDR_enable          = ctrl_q.mdrEnable;
    assign read                = ctrl_q.read;
    assign HI_enable           = ctrl_q.hiEnable;
    assign LO_enable           = ctrl_q.loEnable;
    assign rf_out_en           = ctrl_q.rfOutEn;
    assign rf_write_en         = ctrl_q.rfWriteEn;
    assign halted              = ctrl_q.halted;
    assign instr_done          = ctrl_q.instrDone;
    assign rf_out_addr         = rfOutAddr_q;
    assign rf_write_addr       = rfWriteAddr_q;
    assign alu_instruction     = aluInstr_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer
// Directed-vector bench for alu_instr_sequencer. Every cycle of each instruction
// is compared against a hand-built expected control word; addresses and the
// ALU opcode are compared in the states where they matter.
module tb_alu_instr_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir_in;
`ifdef SINGLE_STEP_EN
    logic        step;
`endif
    logic        PC_select, Z_LO_select, Z_HI_select, MDR_select;
    logic        PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
    logic        MAR_enable, MDR_enable, read, HI_enable, LO_enable;
    logic        rf_out_en, rf_write_en, halted, instr_done;
    logic [3:0]  rf_out_addr, rf_write_addr;
    logic [4:0]  alu_instruction;

    int nChecks;
    int nBad;

    localparam logic [17:0] B_PCS  = 18'b1 << 17;
    localparam logic [17:0] B_ZLO  = 18'b1 << 16;
    localparam logic [17:0] B_ZHI  = 18'b1 << 15;
    localparam logic [17:0] B_MDRS = 18'b1 << 14;
    localparam logic [17:0] B_PCE  = 18'b1 << 13;
    localparam logic [17:0] B_PCI  = 18'b1 << 12;
    localparam logic [17:0] B_IRE  = 18'b1 << 11;
    localparam logic [17:0] B_YE   = 18'b1 << 10;
    localparam logic [17:0] B_ZE   = 18'b1 << 9;
    localparam logic [17:0] B_MARE = 18'b1 << 8;
    localparam logic [17:0] B_MDRE = 18'b1 << 7;
    localparam logic [17:0] B_READ = 18'b1 << 6;
    localparam logic [17:0] B_HIE  = 18'b1 << 5;
    localparam logic [17:0] B_LOE  = 18'b1 << 4;
    localparam logic [17:0] B_RFO  = 18'b1 << 3;
    localparam logic [17:0] B_RFW  = 18'b1 << 2;
    localparam logic [17:0] B_HALT = 18'b1 << 1;
    localparam logic [17:0] B_DONE = 18'b1;

    localparam logic [17:0] EXP_ZERO = 18'b0;
    localparam logic [17:0] EXP_T0   = B_PCS | B_MARE | B_PCI | B_ZE;
    localparam logic [17:0] EXP_T1F  = B_ZLO | B_PCE | B_READ | B_MDRE;
    localparam logic [17:0] EXP_T1S  = B_ZLO | B_READ | B_MDRE;
    localparam logic [17:0] EXP_T2   = B_MDRS | B_IRE;
    localparam logic [17:0] EXP_T3   = B_RFO | B_YE;
    localparam logic [17:0] EXP_T4   = B_RFO | B_ZE;
    localparam logic [17:0] EXP_T5   = B_ZLO | B_RFW | B_DONE;
    localparam logic [17:0] EXP_T5M  = B_ZLO | B_LOE;
    localparam logic [17:0] EXP_T6   = B_ZHI | B_HIE | B_DONE;
    localparam logic [17:0] EXP_U4   = B_RFO | B_ZE;
    localparam logic [17:0] EXP_U5   = B_ZLO | B_RFW | B_DONE;

    localparam logic [17:0] OR_EXP    [6] = '{EXP_T0, EXP_T1F, EXP_T2, EXP_T3, EXP_T4, EXP_T5};
    localparam logic [17:0] STALL_EXP [9] = '{EXP_T0, EXP_T1F, EXP_T1S, EXP_T1S, EXP_T1S,
                                              EXP_T2, EXP_T3, EXP_T4, EXP_T5};
    localparam logic [17:0] MUL_EXP   [7] = '{EXP_T0, EXP_T1F, EXP_T2, EXP_T3, EXP_T4,
                                              EXP_T5M, EXP_T6};
    localparam logic [17:0] NOT_EXP   [6] = '{EXP_T0, EXP_T1F, EXP_T2, EXP_ZERO, EXP_U4, EXP_U5};
    localparam logic [17:0] ILL_EXP   [5] = '{EXP_T0, EXP_T1F, EXP_T2, EXP_ZERO, B_HALT};

    logic [17:0] ctrlVec;
    assign ctrlVec = {PC_select, Z_LO_select, Z_HI_select, MDR_select, PC_enable,
                      PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable,
                      MDR_enable, read, HI_enable, LO_enable, rf_out_en, rf_write_en,
                      halted, instr_done};

    alu_instr_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
`ifdef SINGLE_STEP_EN
        .step                (step),
`endif
        .run                 (run),
        .mem_ready           (mem_ready),
        .ir_in               (ir_in),
        .PC_select           (PC_select),
        .Z_LO_select         (Z_LO_select),
        .Z_HI_select         (Z_HI_select),
        .MDR_select          (MDR_select),
        .PC_enable           (PC_enable),
        .PC_increment_enable (PC_increment_enable),
        .IR_enable           (IR_enable),
        .Y_enable            (Y_enable),
        .Z_enable            (Z_enable),
        .MAR_enable          (MAR_enable),
        .MDR_enable          (MDR_enable),
        .read                (read),
        .HI_enable           (HI_enable),
        .LO_enable           (LO_enable),
        .rf_out_en           (rf_out_en),
        .rf_out_addr         (rf_out_addr),
        .rf_write_en         (rf_write_en),
        .rf_write_addr       (rf_write_addr),
        .alu_instruction     (alu_instruction),
        .halted              (halted),
        .instr_done          (instr_done)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the datapath-side inputs
    task automatic applyStimulus(input logic [31:0] ir, input logic runVal, input logic ready);
        ir_in     = ir;
        run       = runVal;
        mem_ready = ready;
    endtask

    // Advance one clock and settle just past the edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, then release just after an edge
    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0);
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int readCnt;
        int pcEnCnt;
        int doneCyc;
        nChecks = 0;
        nBad    = 0;

        // ---------------- reset state ----------------
        applyReset();
        checkOutput("rst_ctrl", 32'(ctrlVec), 32'(EXP_ZERO));
        checkOutput("rst_alu", 32'(alu_instruction), 32'h0);
        checkOutput("rst_rfo", 32'(rf_out_addr), 32'h0);
        checkOutput("rst_rfw", 32'(rf_write_addr), 32'h0);
        stepCycle();
        checkOutput("idle_norun", 32'(ctrlVec), 32'(EXP_ZERO));

        // ---------------- OR r1,r2,r3; run drops after T0 ----------------
        applyStimulus(32'h30918000, 1'b1, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            stepCycle();
            checkOutput($sformatf("or_c%0d", c), 32'(ctrlVec), 32'(OR_EXP[c-1]));
            if (c == 1) run = 1'b0;
            if (c == 4) checkOutput("or_t3_rfo", 32'(rf_out_addr), 32'd2);
            if (c == 5) begin
                checkOutput("or_t4_rfo", 32'(rf_out_addr), 32'd3);
                checkOutput("or_t4_alu", 32'(alu_instruction), 32'h06);
            end
            if (c == 6) begin
                checkOutput("or_t5_rfw", 32'(rf_write_addr), 32'd1);
                checkOutput("or_t5_alu", 32'(alu_instruction), 32'h0);
            end
        end
        stepCycle();
        checkOutput("or_after", 32'(ctrlVec), 32'(EXP_ZERO));
        stepCycle();
        checkOutput("or_idle", 32'(ctrlVec), 32'(EXP_ZERO));

        // ---------------- fetch stall: mem_ready low 3 cycles of T1 ----------------
        applyReset();
        applyStimulus(32'h30918000, 1'b1, 1'b0);
        readCnt = 0;
        pcEnCnt = 0;
        doneCyc = 0;
        for (int c = 1; c <= 9; c++) begin
            stepCycle();
            checkOutput($sformatf("stall_c%0d", c), 32'(ctrlVec), 32'(STALL_EXP[c-1]));
            if (read) readCnt++;
            if (PC_enable) pcEnCnt++;
            if (instr_done && doneCyc == 0) doneCyc = c;
            if (c == 5) mem_ready = 1'b1;
        end
        checkOutput("stall_reads", 32'(readCnt), 32'd4);
        checkOutput("stall_pcen", 32'(pcEnCnt), 32'd1);
        checkOutput("stall_done", 32'(doneCyc), 32'd9);
`ifndef SINGLE_STEP_EN
        stepCycle();
        checkOutput("stall_b2b_t0", 32'(ctrlVec), 32'(EXP_T0));
`endif

        // ---------------- MUL r1,r2 ----------------
        applyReset();
        applyStimulus(32'h78900000, 1'b1, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            stepCycle();
            checkOutput($sformatf("mul_c%0d", c), 32'(ctrlVec), 32'(MUL_EXP[c-1]));
            if (c == 1) run = 1'b0;
            if (c == 4) checkOutput("mul_t3_rfo", 32'(rf_out_addr), 32'd1);
            if (c == 5) begin
                checkOutput("mul_t4_rfo", 32'(rf_out_addr), 32'd2);
                checkOutput("mul_t4_alu", 32'(alu_instruction), 32'h0F);
            end
        end
        stepCycle();
        checkOutput("mul_after", 32'(ctrlVec), 32'(EXP_ZERO));

        // ---------------- NOT r5,r7 (unary) ----------------
        applyReset();
        applyStimulus(32'h92B80000, 1'b1, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            stepCycle();
            checkOutput($sformatf("not_c%0d", c), 32'(ctrlVec), 32'(NOT_EXP[c-1]));
            if (c == 1) run = 1'b0;
            if (c == 5) begin
                checkOutput("not_u4_rfo", 32'(rf_out_addr), 32'd7);
                checkOutput("not_u4_alu", 32'(alu_instruction), 32'h12);
            end
            if (c == 6) checkOutput("not_u5_rfw", 32'(rf_write_addr), 32'd5);
        end

        // ---------------- illegal opcode 11111 ----------------
        applyReset();
        applyStimulus(32'hF8000000, 1'b1, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            stepCycle();
            checkOutput($sformatf("ill_c%0d", c), 32'(ctrlVec), 32'(ILL_EXP[c-1]));
        end
        for (int k = 0; k < 4; k++) begin
            run = k[0];
            stepCycle();
            checkOutput($sformatf("ill_hold%0d", k), 32'(ctrlVec), 32'(B_HALT));
        end
        checkOutput("ill_alu", 32'(alu_instruction), 32'h0);

        // ---------------- asynchronous reset during T4 ----------------
        applyReset();
        applyStimulus(32'h30918000, 1'b1, 1'b1);
        repeat (5) stepCycle();
        checkOutput("arst_pre_t4", 32'(ctrlVec), 32'(EXP_T4));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_ctrl", 32'(ctrlVec), 32'(EXP_ZERO));
        checkOutput("arst_rfo", 32'(rf_out_addr), 32'h0);
        checkOutput("arst_alu", 32'(alu_instruction), 32'h0);
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        stepCycle();
        checkOutput("arst_idle", 32'(ctrlVec), 32'(EXP_ZERO));
        run = 1'b1;
        stepCycle();
        checkOutput("arst_t0", 32'(ctrlVec), 32'(EXP_T0));

`ifdef SINGLE_STEP_EN
        // ---------------- single step: two back-to-back ORs ----------------
        applyReset();
        applyStimulus(32'h30918000, 1'b1, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            stepCycle();
            checkOutput($sformatf("step_or_c%0d", c), 32'(ctrlVec), 32'(OR_EXP[c-1]));
        end
        stepCycle();
        checkOutput("step_wait1", 32'(ctrlVec), 32'(EXP_ZERO));
        stepCycle();
        checkOutput("step_wait2", 32'(ctrlVec), 32'(EXP_ZERO));
        step = 1'b1;
        stepCycle();
        checkOutput("step_t0", 32'(ctrlVec), 32'(EXP_T0));
        step = 1'b0;
        stepCycle();
        checkOutput("step_t1", 32'(ctrlVec), 32'(EXP_T1F));
`endif

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
